// File: rtl/tag_anc_pkg.sv
// Shared definitions for the tag RX sync sequencer: FSM encodings, default GPIO
// masks and the saturating negate used on the baseband Q path.
package tag_anc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_PREAMBLE = 2'b01,
    ST_DATA     = 2'b10,
    ST_DONE     = 2'b11
  } rx_state_t;

  localparam logic [11:0] DEF_SYNC_OUT_MASK = 12'h001;
  localparam logic [11:0] DEF_RX_OUT_MASK   = 12'h010;
  localparam logic [11:0] DEF_SYNC_IN_MASK  = 12'h004;

  // Widest sample the negate helper handles; callers sign-extend into it.
  localparam int SAT_W = 32;

  // Negate a w-bit two's complement value held sign-extended in SAT_W bits.
  // The most negative w-bit value maps to the most positive instead of wrapping.
  function automatic logic signed [SAT_W-1:0] sat_neg(
    input logic signed [SAT_W-1:0] x,
    input int unsigned             w
  );
    longint xl;
    longint mn;
    xl = longint'(x);
    mn = -(longint'(1) << (w - 1));
    if (xl == mn) return SAT_W'(-mn - 1);
    return SAT_W'(-xl);
  endfunction

endpackage

// File: rtl/gpio_trig_sync.sv
// GPIO trigger conditioner: masked OR of the raw inputs, two-flop synchronizer
// and a registered rising-edge pulse (pulse lands 3 cycles after the pin edge).
module gpio_trig_sync
  import tag_anc_pkg::*;
#(
  parameter int                        GPIO_REG_WIDTH = 12,
  parameter logic [GPIO_REG_WIDTH-1:0] IN_MASK        = GPIO_REG_WIDTH'(DEF_SYNC_IN_MASK)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [GPIO_REG_WIDTH-1:0] gpio_in,
  output logic                      trig
);

  logic trig_raw;
  logic sync_p0;
  logic sync_p1;
  logic prev_p2;

  assign trig_raw = |(gpio_in & IN_MASK);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
      trig    <= 1'b0;
    end else begin
      sync_p0 <= trig_raw;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
      trig    <= sync_p1 & ~prev_p2;
    end
  end

endmodule

// File: rtl/tag_rx_sync_seq.sv
// Tag RX sync sequencer: GPIO trigger -> BPSK preamble -> demod soft reset ->
// baseband pass-through until block done. Watchdog built with TAG_RX_SYNC_TIMEOUT_EN.
module tag_rx_sync_seq
  import tag_anc_pkg::*;
#(
  parameter int                        DATA_WIDTH     = 16,
  parameter int                        GPIO_REG_WIDTH = 12,
  parameter int                        NSYNC          = 2,
  parameter logic [31:0]               SYNC_PATTERN   = 32'h1,
  parameter int                        SYNC_LEN       = 8000,
  parameter int                        SYNC_AMP       = 16384,
  parameter bit                        Q_INV          = 1'b1,
  parameter logic [GPIO_REG_WIDTH-1:0] SYNC_OUT_MASK  = GPIO_REG_WIDTH'(DEF_SYNC_OUT_MASK),
  parameter logic [GPIO_REG_WIDTH-1:0] RX_OUT_MASK    = GPIO_REG_WIDTH'(DEF_RX_OUT_MASK),
  parameter logic [GPIO_REG_WIDTH-1:0] SYNC_IN_MASK   = GPIO_REG_WIDTH'(DEF_SYNC_IN_MASK),
  parameter int                        TIMEOUT        = 1 << 20
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [GPIO_REG_WIDTH-1:0]    gpio_in,
  output logic [GPIO_REG_WIDTH-1:0]    gpio_out,
  input  logic signed [DATA_WIDTH-1:0] irx_bb,
  input  logic signed [DATA_WIDTH-1:0] qrx_bb,
  input  logic                         rx_sync_ready,
  output logic                         rx_srst,
  output logic                         rx_valid,
  output logic signed [DATA_WIDTH-1:0] irx_out,
  output logic signed [DATA_WIDTH-1:0] qrx_out,
  output logic                         out_sel,
  output logic [1:0]                   rx_state,
  output logic [4:0]                   sym_idx,
  output logic                         err
);

  localparam int                            CNT_W    = $clog2(SYNC_LEN);
  localparam logic [CNT_W-1:0]              CNT_LAST = CNT_W'(SYNC_LEN - 1);
  localparam logic [4:0]                    SYM_LAST = 5'(NSYNC - 1);
  localparam logic signed [DATA_WIDTH-1:0]  AMP_POS  = DATA_WIDTH'(SYNC_AMP);
  localparam logic signed [DATA_WIDTH-1:0]  AMP_NEG  = -AMP_POS;

  rx_state_t                     state_q;
  rx_state_t                     state_nxt;
  logic [CNT_W-1:0]              cnt_q;
  logic [CNT_W-1:0]              cnt_nxt;
  logic [4:0]                    sym_q;
  logic [4:0]                    sym_nxt;
  logic                          trig;
  logic                          rsr_q;
  logic                          rsr_rise;
  logic                          cnt_last;
  logic                          sym_last;
  logic                          wd_expire;

  logic                          vld_p0;
  logic                          sel_p0;
  logic                          srst_p0;
  logic signed [DATA_WIDTH-1:0]  irx_p0;
  logic signed [DATA_WIDTH-1:0]  qrx_p0;
  logic signed [DATA_WIDTH-1:0]  qbb_p0;

  gpio_trig_sync #(
    .GPIO_REG_WIDTH (GPIO_REG_WIDTH),
    .IN_MASK        (SYNC_IN_MASK)
  ) u_trig (
    .clk     (clk),
    .reset   (reset),
    .gpio_in (gpio_in),
    .trig    (trig)
  );

  assign rsr_rise = rx_sync_ready & ~rsr_q;
  assign cnt_last = (cnt_q == CNT_LAST);
  assign sym_last = (sym_q == SYM_LAST);
  assign rx_state = state_q;
  assign sym_idx  = sym_q;

`ifdef TAG_RX_SYNC_TIMEOUT_EN
  logic [31:0] wd_q;

  assign wd_expire = (state_q == ST_DATA) && (wd_q == 32'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_q <= '0;
      err  <= 1'b0;
    end else begin
      wd_q <= (state_q == ST_DATA) ? wd_q + 32'd1 : 32'd0;
      if (wd_expire && !rsr_rise) err <= 1'b1;
    end
  end
`else
  logic timeout_unused;

  assign timeout_unused = (TIMEOUT > 0);
  assign wd_expire      = 1'b0;
  assign err            = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sym_q   <= '0;
      rsr_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      sym_q   <= sym_nxt;
      rsr_q   <= rx_sync_ready;
    end
  end

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    sym_nxt   = sym_q;
    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          state_nxt = ST_PREAMBLE;
          cnt_nxt   = '0;
          sym_nxt   = '0;
        end
      end
      ST_PREAMBLE: begin
        if (cnt_last) begin
          cnt_nxt = '0;
          // sym_idx parks on the last symbol rather than running past it
          if (sym_last) state_nxt = ST_DATA;
          else          sym_nxt   = sym_q + 5'd1;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (rsr_rise || wd_expire) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign qbb_p0 = Q_INV ? DATA_WIDTH'(sat_neg(SAT_W'(qrx_bb), DATA_WIDTH)) : qrx_bb;

  always_comb begin
    vld_p0  = 1'b0;
    sel_p0  = 1'b0;
    srst_p0 = 1'b0;
    irx_p0  = irx_bb;
    qrx_p0  = qbb_p0;
    case (state_q)
      ST_PREAMBLE: begin
        vld_p0  = 1'b1;
        sel_p0  = 1'b1;
        srst_p0 = cnt_last && sym_last;
        irx_p0  = SYNC_PATTERN[sym_q] ? AMP_POS : AMP_NEG;
        qrx_p0  = '0;
      end
      ST_DATA: vld_p0 = 1'b1;
      default: ;
    endcase
  end

  // p0 -> output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_valid <= 1'b0;
      out_sel  <= 1'b0;
      rx_srst  <= 1'b0;
      irx_out  <= '0;
      qrx_out  <= '0;
      gpio_out <= '0;
    end else begin
      rx_valid <= vld_p0;
      out_sel  <= sel_p0;
      rx_srst  <= srst_p0;
      irx_out  <= irx_p0;
      qrx_out  <= qrx_p0;
      gpio_out <= (rx_sync_ready ? SYNC_OUT_MASK : '0) | (rx_valid ? RX_OUT_MASK : '0);
    end
  end

endmodule

// File: tb/tb_tag_rx_sync_seq.sv
// Directed bench for tag_rx_sync_seq with a short 4-symbol preamble (pattern 0110, 8 samples).
module tb_tag_rx_sync_seq;

`ifdef TAG_RX_SYNC_TIMEOUT_EN
  localparam int TB_TIMEOUT = 50;
`else
  localparam int TB_TIMEOUT = 1 << 20;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] gpio_in;
  logic [11:0] gpio_out;
  logic [15:0] irx_bb;
  logic [15:0] qrx_bb;
  logic        rx_sync_ready;
  logic        rx_srst;
  logic        rx_valid;
  logic [15:0] irx_out;
  logic [15:0] qrx_out;
  logic        out_sel;
  logic [1:0]  rx_state;
  logic [4:0]  sym_idx;
  logic        err;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tag_rx_sync_seq #(
    .DATA_WIDTH     (16),
    .GPIO_REG_WIDTH (12),
    .NSYNC          (4),
    .SYNC_PATTERN   (32'h6),
    .SYNC_LEN       (8),
    .SYNC_AMP       (16384),
    .Q_INV          (1'b1),
    .SYNC_OUT_MASK  (12'h001),
    .RX_OUT_MASK    (12'h010),
    .SYNC_IN_MASK   (12'h004),
    .TIMEOUT        (TB_TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .gpio_in       (gpio_in),
    .gpio_out      (gpio_out),
    .irx_bb        (irx_bb),
    .qrx_bb        (qrx_bb),
    .rx_sync_ready (rx_sync_ready),
    .rx_srst       (rx_srst),
    .rx_valid      (rx_valid),
    .irx_out       (irx_out),
    .qrx_out       (qrx_out),
    .out_sel       (out_sel),
    .rx_state      (rx_state),
    .sym_idx       (sym_idx),
    .err           (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (rx_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; gpio_in = '0; irx_bb = '0; qrx_bb = '0; rx_sync_ready = 1'b0;
    #2;
    vectors++;
    if ({gpio_out, rx_valid, rx_srst, out_sel, irx_out, qrx_out, rx_state, sym_idx, err} !== '0) begin
      miscompares++;
      $display("FAIL reset_state got gpio=%h v=%b s=%b sel=%b i=%h q=%h st=%0d sym=%0d err=%b want all 0",
               gpio_out, rx_valid, rx_srst, out_sel, irx_out, qrx_out, rx_state, sym_idx, err);
    end
    tick(); tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  // Full preamble; optionally wiggles the trigger and rx_sync_ready mid-way.
  task automatic test_preamble(input bit disturb);
    logic [3:0]  pat;
    logic [15:0] exp_i;
    logic [4:0]  exp_sym;
    logic [1:0]  exp_st;
    int n;
    pat = 4'b0110;
    gpio_in = 12'h004;
    wait_valid(n);
    vectors++;
    if (n !== 5) begin
      miscompares++;
      $display("FAIL trig_latency got %0d want 5", n);
    end
    for (int i = 0; i < 32; i++) begin
      exp_i   = pat[i / 8] ? 16'h4000 : 16'hC000;
      exp_sym = (i == 31) ? 5'd3 : 5'((i + 1) / 8);
      exp_st  = (i == 31) ? 2'b10 : 2'b01;
      vectors++;
      if ({rx_valid, out_sel, rx_srst, irx_out, qrx_out, sym_idx, rx_state} !==
          {1'b1, 1'b1, (i == 31), exp_i, 16'h0000, exp_sym, exp_st}) begin
        miscompares++;
        $display("FAIL preamble_s%0d got v=%b sel=%b srst=%b i=%h q=%h sym=%0d st=%0d want v=1 sel=1 srst=%b i=%h q=0 sym=%0d st=%0d",
                 i, rx_valid, out_sel, rx_srst, irx_out, qrx_out, sym_idx, rx_state,
                 (i == 31), exp_i, exp_sym, exp_st);
      end
      if (i == 20) begin
        vectors++;
        if (gpio_out !== 12'h010) begin
          miscompares++;
          $display("FAIL preamble_gpio got %h want 010", gpio_out);
        end
      end
      if (disturb) begin
        if (i == 3)  gpio_in = 12'h000;
        if (i == 6)  gpio_in = 12'h004;
        if (i == 10) rx_sync_ready = 1'b1;
        if (i == 12) rx_sync_ready = 1'b0;
      end
      if (i != 31) tick();
    end
  endtask

  task automatic test_baseband();
    logic [15:0] bi [4] = '{16'd100, 16'hFFFB, 16'h0000, 16'h7FFF};
    logic [15:0] bq [4] = '{16'h8000, 16'h0007, 16'hFFFF, 16'h7FFF};
    logic [15:0] eq [4] = '{16'h7FFF, 16'hFFF9, 16'h0001, 16'h8001};
    for (int k = 0; k < 4; k++) begin
      irx_bb = bi[k];
      qrx_bb = bq[k];
      tick();
      vectors++;
      if ({irx_out, qrx_out, out_sel, rx_valid, rx_srst, rx_state} !== {bi[k], eq[k], 1'b0, 1'b1, 1'b0, 2'b10}) begin
        miscompares++;
        $display("FAIL baseband_%0d got i=%h q=%h sel=%b v=%b srst=%b st=%0d want i=%h q=%h sel=0 v=1 srst=0 st=2",
                 k, irx_out, qrx_out, out_sel, rx_valid, rx_srst, rx_state, bi[k], eq[k]);
      end
    end
  endtask

  // rx_sync_ready edge ends the block; a trigger arriving in DONE is dropped.
  task automatic test_block_end();
    gpio_in = 12'h000;
    tick(); tick(); tick();
    gpio_in = 12'h004;
    tick(); tick();
    rx_sync_ready = 1'b1;
    tick();
    vectors++;
    if ({rx_state, gpio_out} !== {2'b11, 12'h011}) begin
      miscompares++;
      $display("FAIL done_state got st=%0d gpio=%h want st=3 gpio=011", rx_state, gpio_out);
    end
    tick();
    vectors++;
    if ({rx_state, rx_valid, out_sel, gpio_out} !== {2'b00, 1'b0, 1'b0, 12'h011}) begin
      miscompares++;
      $display("FAIL done_exit got st=%0d v=%b sel=%b gpio=%h want st=0 v=0 sel=0 gpio=011",
               rx_state, rx_valid, out_sel, gpio_out);
    end
    tick();
    vectors++;
    if (gpio_out !== 12'h001) begin
      miscompares++;
      $display("FAIL gpio_sync_only got %h want 001", gpio_out);
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      vectors++;
      if ({rx_state, rx_valid} !== {2'b00, 1'b0}) begin
        miscompares++;
        $display("FAIL no_retrigger_%0d got st=%0d v=%b want st=0 v=0", k, rx_state, rx_valid);
      end
    end
    rx_sync_ready = 1'b0;
    tick(); tick();
    vectors++;
    if (gpio_out !== 12'h000) begin
      miscompares++;
      $display("FAIL gpio_idle got %h want 000", gpio_out);
    end
  endtask

  task automatic test_async_reset();
    int n;
    gpio_in = 12'h000;
    tick(); tick(); tick();
    gpio_in = 12'h004;
    wait_valid(n);
    for (int k = 0; k < 20; k++) tick();
    vectors++;
    if ({rx_state, sym_idx, irx_out} !== {2'b01, 5'd2, 16'h4000}) begin
      miscompares++;
      $display("FAIL pre_reset_pos got st=%0d sym=%0d i=%h want st=1 sym=2 i=4000", rx_state, sym_idx, irx_out);
    end
    #1;
    reset = 1'b1;
    gpio_in = 12'h000;
    #1;
    vectors++;
    if ({gpio_out, rx_valid, rx_srst, out_sel, irx_out, qrx_out, rx_state, sym_idx, err} !== '0) begin
      miscompares++;
      $display("FAIL async_reset got gpio=%h v=%b s=%b sel=%b i=%h q=%h st=%0d sym=%0d err=%b want all 0",
               gpio_out, rx_valid, rx_srst, out_sel, irx_out, qrx_out, rx_state, sym_idx, err);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if (rx_srst !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_srst_%0d got %b want 0", k, rx_srst);
      end
    end
    reset = 1'b0;
    tick(); tick();
    gpio_in = 12'h004;
    wait_valid(n);
    vectors++;
    if ({n[3:0], sym_idx, irx_out, rx_state} !== {4'd5, 5'd0, 16'hC000, 2'b01}) begin
      miscompares++;
      $display("FAIL restart got n=%0d sym=%0d i=%h st=%0d want n=5 sym=0 i=c000 st=1", n, sym_idx, irx_out, rx_state);
    end
    n = 0;
    while (rx_srst !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    vectors++;
    if (n !== 31) begin
      miscompares++;
      $display("FAIL restart_srst got %0d cycles want 31", n);
    end
  endtask

  task automatic test_watchdog();
    rx_sync_ready = 1'b0;
`ifdef TAG_RX_SYNC_TIMEOUT_EN
    for (int k = 0; k < 49; k++) tick();
    vectors++;
    if ({rx_state, err} !== {2'b10, 1'b0}) begin
      miscompares++;
      $display("FAIL wd_before got st=%0d err=%b want st=2 err=0", rx_state, err);
    end
    tick();
    vectors++;
    if ({rx_state, err} !== {2'b11, 1'b1}) begin
      miscompares++;
      $display("FAIL wd_fire got st=%0d err=%b want st=3 err=1", rx_state, err);
    end
    for (int k = 0; k < 6; k++) tick();
    vectors++;
    if ({rx_state, err} !== {2'b00, 1'b1}) begin
      miscompares++;
      $display("FAIL wd_sticky got st=%0d err=%b want st=0 err=1", rx_state, err);
    end
`else
    for (int k = 0; k < 60; k++) tick();
    vectors++;
    if ({rx_state, err, rx_valid} !== {2'b10, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL no_wd got st=%0d err=%b v=%b want st=2 err=0 v=1", rx_state, err, rx_valid);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_preamble(1'b1);
    test_baseband();
    test_block_end();
    test_async_reset();
    test_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got still running want finished");
    $fatal(1, "bench time limit");
  end

endmodule
